// File: rtl/lut_neuron_array.sv
// Purpose: array of N_NEURONS LUT neurons sharing one input vector, with CONFIG/RUN/DRAIN table-load control.
// Latency: 2 cycles from accepted input to out_valid (S1 = address register, S2 = table-read register).
// Backpressure: valid/ready; both stages freeze while out_valid && !out_ready, in_ready drops only in that case or outside RUN.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   in_valid/in_ready/in_data      input vector; neuron k's address in in_data[k*ADDR_W +: ADDR_W]
//   out_valid/out_ready/out_data   result vector; neuron k's output in out_data[k*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_sel/cfg_addr/cfg_data  table write port (legal only in CONFIG with cfg_sel < N_NEURONS)
//   cfg_lock/cfg_unlock            CONFIG->RUN and RUN->DRAIN requests
//   state                          00 CONFIG, 01 RUN, 10 DRAIN
//   cfg_err                        sticky illegal-write flag, cleared only by rst
module lut_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int FAN_IN    = 3,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2,
    localparam int ADDR_W   = FAN_IN * IN_BITS,
    localparam int SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_NEURONS*ADDR_W-1:0]     in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0]   out_data,
    input  logic                            cfg_we,
    input  logic [SEL_W-1:0]                cfg_sel,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    input  logic                            cfg_lock,
    input  logic                            cfg_unlock,
    output logic [1:0]                      state,
    output logic                            cfg_err
);

    typedef enum logic [1:0] {
        ST_CONFIG = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10
    } state_t;

    // One extra bit so an out-of-range index can be compared against N_NEURONS.
    localparam logic [SEL_W:0] N_SEL = N_NEURONS[SEL_W:0];

    state_t                          st;
    logic                            s1_vld;
    logic [N_NEURONS*ADDR_W-1:0]     s1_dat;
    logic                            s2_vld;
    logic [N_NEURONS*OUT_BITS-1:0]   s2_dat;
    logic [N_NEURONS*OUT_BITS-1:0]   rd_dat;
    logic                            adv;
    logic                            xfer;
    logic                            sel_ok;
    logic                            wr_en;

    assign adv      = !s2_vld || out_ready;
    assign in_ready = (st == ST_RUN) && adv;
    assign xfer     = in_valid && in_ready;
    assign sel_ok   = ({1'b0, cfg_sel} < N_SEL);
    assign wr_en    = cfg_we && (st == ST_CONFIG) && sel_ok;

    assign out_valid = s2_vld;
    assign out_data  = s2_dat;
    assign state     = st;

    // Per-neuron truth table: synchronous write, asynchronous read (distributed RAM).
    // Tables are deliberately outside the reset domain so contents survive rst.
    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        localparam logic [SEL_W-1:0] K_SEL = SEL_W'(k);
        logic [OUT_BITS-1:0] tbl [0:(1<<ADDR_W)-1];

        always_ff @(posedge clk) begin
            if (wr_en && (cfg_sel == K_SEL)) begin
                tbl[cfg_addr] <= cfg_data;
            end
        end

        assign rd_dat[k*OUT_BITS +: OUT_BITS] = tbl[s1_dat[k*ADDR_W +: ADDR_W]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_CONFIG;
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_we && !((st == ST_CONFIG) && sel_ok)) begin
                cfg_err <= 1'b1;
            end

            if (adv) begin
                s1_vld <= xfer;
                if (xfer) begin
                    s1_dat <= in_data;
                end
                s2_vld <= s1_vld;
                // Only load S2 from a live S1 so out_data never shows unwritten table cells.
                if (s1_vld) begin
                    s2_dat <= rd_dat;
                end
            end

            case (st)
                ST_CONFIG: if (cfg_lock)   st <= ST_RUN;
                ST_RUN:    if (cfg_unlock) st <= ST_DRAIN;
                ST_DRAIN:  if (!s1_vld && !s2_vld) st <= ST_CONFIG;
                default:   st <= ST_CONFIG;
            endcase
        end
    end

endmodule
